// File: rtl/ic_ram_pkg.sv
// Shared definitions for the simple dual-port RAM: clear/ready state encoding
// and the range of supported read latencies.
package ic_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/ic_ram_clr.sv
// Post-reset zero-fill sequencer: walks every address once, then hands the
// array over to the user ports.
module ic_ram_clr
    import ic_ram_pkg::*;
#(
    parameter int RAM_AW     = 9,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [RAM_AW-1:0] clr_addr,
    output logic              init_busy
);

    localparam clr_state_e RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;

    clr_state_e        state_reg, state_next;
    logic [RAM_AW-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RST_STATE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Leave CLEAR on the same edge that writes the last entry.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == ST_CLEAR) begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == {RAM_AW{1'b1}}) begin
                state_next = ST_READY;
                cnt_next   = '0;
            end
        end
    end

    always_comb begin
        clr_we    = (state_reg == ST_CLEAR);
        init_busy = (state_reg == ST_CLEAR);
    end

    assign clr_addr = cnt_reg;

endmodule

// File: rtl/ic_ram_sdp.sv
// Simple dual-port RAM: byte-lane writes on port A, pipelined write-first
// reads on port B, optional zero-fill after reset.
module ic_ram_sdp
    import ic_ram_pkg::*;
#(
    parameter int RAM_DW     = 128,
    parameter int RAM_AW     = 9,
    parameter int RD_LAT     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wea,
    input  logic [RAM_DW/8-1:0] bea,
    input  logic [RAM_AW-1:0]   addra,
    input  logic [RAM_DW-1:0]   dina,
    input  logic                reb,
    input  logic [RAM_AW-1:0]   addrb,
    output logic [RAM_DW-1:0]   doutb,
    output logic                doutb_vld,
    output logic                init_busy
);

    localparam int NB = RAM_DW / 8;
    localparam int DP = 1 << RAM_AW;

    if ((RAM_DW < 8) || (RAM_DW % 8 != 0)) begin : g_bad_dw
        $error("ic_ram_sdp: RAM_DW must be a positive multiple of 8");
    end
    if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
        $error("ic_ram_sdp: RD_LAT must be 1 or 2");
    end

    logic              clr_we;
    logic [RAM_AW-1:0] clr_addr;

    ic_ram_clr #(
        .RAM_AW     (RAM_AW),
        .CLR_ON_RST (CLR_ON_RST)
    ) u_clr (
        .clk       (clk),
        .rst       (rst),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_busy (init_busy)
    );

    logic [RAM_DW-1:0] mem [DP];

    logic [NB-1:0]     wr_lane_en;
    logic [RAM_AW-1:0] wr_addr;
    logic [RAM_DW-1:0] wr_data;
    logic              rd_acc;

    // The clear sequencer owns the write port until it finishes.
    always_comb begin
        wr_lane_en = '0;
        wr_addr    = addra;
        wr_data    = dina;
        if (clr_we) begin
            wr_lane_en = '1;
            wr_addr    = clr_addr;
            wr_data    = '0;
        end else if (wea) begin
            wr_lane_en = bea;
        end
    end

    assign rd_acc = reb && !init_busy;

    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (wr_lane_en[k]) begin
                mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    logic [RAM_DW-1:0] mem_q_reg;

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            mem_q_reg <= mem[addrb];
        end
    end

    // Array read returns pre-write contents; the captured lane mask patches in
    // the bytes written on the same edge.
    logic [NB-1:0]     byp_mask_reg;
    logic [RAM_DW-1:0] byp_data_reg;
    logic              vld1_reg;
    logic              data_ok_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_mask_reg <= '0;
            byp_data_reg <= '0;
            vld1_reg     <= 1'b0;
            data_ok_reg  <= 1'b0;
        end else begin
            vld1_reg <= rd_acc;
            if (rd_acc) begin
                byp_mask_reg <= (wea && (addra == addrb)) ? bea : '0;
                byp_data_reg <= dina;
                data_ok_reg  <= 1'b1;
            end
        end
    end

    logic [RAM_DW-1:0] rd_merged;
    logic [RAM_DW-1:0] stage1_data;

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign rd_merged[8*gi +: 8] = byp_mask_reg[gi] ? byp_data_reg[8*gi +: 8]
                                                        : mem_q_reg[8*gi +: 8];
    end

    // Until the first read completes, the array output register is undefined.
    assign stage1_data = data_ok_reg ? rd_merged : '0;

    if (RD_LAT == 1) begin : g_lat1
        assign doutb     = stage1_data;
        assign doutb_vld = vld1_reg;
    end else begin : g_lat2
        logic [RAM_DW-1:0] doutb_reg;
        logic              vld2_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                doutb_reg <= '0;
                vld2_reg  <= 1'b0;
            end else begin
                vld2_reg <= vld1_reg;
                if (vld1_reg) begin
                    doutb_reg <= stage1_data;
                end
            end
        end

        assign doutb     = doutb_reg;
        assign doutb_vld = vld2_reg;
    end

endmodule

// File: tb/tb_ic_ram_sdp.sv
// Bench for ic_ram_sdp: RD_LAT=1 and RD_LAT=2 instances driven in lockstep,
// each checked against a reference memory model through its own scoreboard.
module tb_ic_ram_sdp;

    localparam int DW = 128;
    localparam int AW = 4;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wea = 1'b0;
    logic [15:0]   bea = '0;
    logic [AW-1:0] addra = '0;
    logic [DW-1:0] dina = '0;
    logic          reb = 1'b0;
    logic [AW-1:0] addrb = '0;

    logic [DW-1:0] doutb1, doutb2;
    logic          vld1, vld2, busy1, busy2;

    always #5 clk = ~clk;

    ic_ram_sdp #(.RAM_DW(DW), .RAM_AW(AW), .RD_LAT(1), .CLR_ON_RST(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
        .reb(reb), .addrb(addrb), .doutb(doutb1), .doutb_vld(vld1), .init_busy(busy1)
    );

    ic_ram_sdp #(.RAM_DW(DW), .RAM_AW(AW), .RD_LAT(2), .CLR_ON_RST(1)) u_dut_l2 (
        .clk(clk), .rst(rst), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
        .reb(reb), .addrb(addrb), .doutb(doutb2), .doutb_vld(vld2), .init_busy(busy2)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          q1[$];
    exp_t          q2[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic [DW-1:0] model [DP];
    bit            tb_ready = 1'b0;
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last2 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (vld1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("l1_unexpected_vld", {{(DW-1){1'b0}}, vld1}, '0);
            end else begin
                e = q1.pop_front();
                chk("l1_data", doutb1, e.data);
                chk("l1_cycle", DW'(cyc), DW'(e.cyc));
                last1 = doutb1;
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (vld2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("l2_unexpected_vld", {{(DW-1){1'b0}}, vld2}, '0);
            end else begin
                e = q2.pop_front();
                chk("l2_data", doutb2, e.data);
                chk("l2_cycle", DW'(cyc), DW'(e.cyc));
                last2 = doutb2;
            end
        end
    end

    // One cycle of stimulus; expected read data is write-first per lane.
    task automatic step(input logic we, input logic [15:0] be, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        exp_t          e;
        logic [DW-1:0] x;
        wea = we; bea = be; addra = wa; dina = wd; reb = re; addrb = ra;
        if (re && tb_ready) begin
            x = model[ra];
            for (int k = 0; k < DW/8; k++) begin
                if (we && (wa == ra) && be[k]) x[8*k +: 8] = wd[8*k +: 8];
            end
            e.data = x;
            e.cyc  = cyc + 1;
            q1.push_back(e);
            e.cyc  = cyc + 2;
            q2.push_back(e);
        end
        if (we && tb_ready) begin
            for (int k = 0; k < DW/8; k++) begin
                if (be[k]) model[wa][8*k +: 8] = wd[8*k +: 8];
            end
        end
        @(negedge clk);
        wea = 1'b0; reb = 1'b0; bea = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    // Counts busy cycles from the current (reset-release) point; optionally
    // drives a write and read at addr 9 for the first 10 cycles.
    task automatic count_fill(input bit poke, output int n1, output int n2);
        n1 = 0; n2 = 0;
        for (int i = 0; i < 40; i++) begin
            if (poke && i < 10) begin
                wea = 1'b1; bea = '1; addra = 4'd9; dina = '1; reb = 1'b1; addrb = 4'd9;
            end else begin
                wea = 1'b0; reb = 1'b0; bea = '0;
            end
            if (busy1) n1++;
            if (busy2) n2++;
            @(negedge clk);
        end
    endtask

    initial begin : main
        int            n1, n2;
        logic [DW-1:0] d0123, fill11, fillff, fillaa, fill55, fill77;
        d0123  = 128'h0123456789ABCDEF0123456789ABCDEF;
        fill11 = {16{8'h11}};
        fillff = {16{8'hFF}};
        fillaa = {16{8'hAA}};
        fill55 = {16{8'h55}};
        fill77 = {16{8'h77}};
        for (int i = 0; i < DP; i++) model[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_doutb_l1", doutb1, '0);
        chk("rst_doutb_l2", doutb2, '0);
        chk("rst_vld_l1", DW'(vld1), '0);
        chk("rst_vld_l2", DW'(vld2), '0);
        chk("rst_busy_l1", DW'(busy1), DW'(1));
        chk("rst_busy_l2", DW'(busy2), DW'(1));

        rst = 1'b0;
        count_fill(1'b1, n1, n2);
        chk("fill_cycles_l1", DW'(n1), DW'(16));
        chk("fill_cycles_l2", DW'(n2), DW'(16));
        chk("busy_done_l1", DW'(busy1), '0);
        tb_ready = 1'b1;

        step(1'b0, '0, '0, '0, 1'b1, 4'd5);
        step(1'b0, '0, '0, '0, 1'b1, 4'd9);
        step(1'b1, 16'hFFFF, 4'd3, d0123, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd3);
        step(1'b1, 16'hFFFF, 4'd2, fill11, 1'b0, '0);
        step(1'b1, 16'h0001, 4'd2, fillff, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd2);
        step(1'b1, 16'hFFFF, 4'd7, fillaa, 1'b0, '0);
        step(1'b1, 16'h00FF, 4'd7, fill55, 1'b1, 4'd7);
        step(1'b0, '0, '0, '0, 1'b1, 4'd7);
        step(1'b1, 16'hFFFF, 4'd4, fill77, 1'b1, 4'd3);
        step(1'b0, '0, '0, '0, 1'b1, 4'd4);
        step(1'b1, 16'h0000, 4'd3, fillff, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd3);
        idle(4);
        chk("hold_l1", doutb1, d0123);
        chk("hold_l2", doutb2, d0123);
        chk("hold_vld_l1", DW'(vld1), '0);

        for (int i = 0; i < DP; i++) step(1'b1, 16'hFFFF, AW'(i), DW'(i + 1), 1'b0, '0);
        for (int i = 0; i < DP; i++) step(1'b0, '0, '0, '0, 1'b1, AW'(i));
        idle(4);
        chk("q_empty_l1", DW'(q1.size()), '0);
        chk("q_empty_l2", DW'(q2.size()), '0);

        rst = 1'b1;
        tb_ready = 1'b0;
        @(negedge clk);
        chk("rst2_doutb_l1", doutb1, '0);
        chk("rst2_doutb_l2", doutb2, '0);
        chk("rst2_busy_l2", DW'(busy2), DW'(1));
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy_l1", DW'(busy1), DW'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_fill(1'b0, n1, n2);
        chk("refill_cycles_l1", DW'(n1), DW'(16));
        chk("refill_cycles_l2", DW'(n2), DW'(16));
        for (int i = 0; i < DP; i++) model[i] = '0;
        tb_ready = 1'b1;
        step(1'b0, '0, '0, '0, 1'b1, 4'd0);
        step(1'b0, '0, '0, '0, 1'b1, 4'd15);
        idle(4);
        chk("final_q_l1", DW'(q1.size()), '0);
        chk("final_q_l2", DW'(q2.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
